// File: rtl/mem_pte_bridge_pkg.sv
// Shared types for the cache-side memory bridge.
//   mem_size_e     : access size carried on req_wmask (byte / half / word)
//   pte_ad_t       : {set_d, set_a} hardware A/D update request flags
//   ERR_BUS/ERR_MISALIGN : values driven on resp_errty
//   bridge_state_e : bridge transaction state
//   pte_ad_mask()  : builds the OR-mask of the requested A/D bits
package mem_pte_bridge_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic set_d;
        logic set_a;
    } pte_ad_t;

    localparam logic [1:0] ERR_BUS      = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_CMD,
        ST_WAIT,
        ST_PTE_CMD,
        ST_PTE_WAIT,
        ST_RESP
    } bridge_state_e;

    function automatic logic [31:0] pte_ad_mask(input pte_ad_t flags,
                                                input int unsigned a_bit,
                                                input int unsigned d_bit);
        return (32'(flags.set_a) << a_bit) | (32'(flags.set_d) << d_bit);
    endfunction

endpackage

// File: rtl/mem_pte_bridge_lane_align.sv
// Combinational byte-lane alignment for the memory bridge.
//   offset_i   : byte offset within the word (addr[1:0])
//   size_i     : access size
//   wdata_i    : right-aligned write data      -> wdata_o : lane-positioned
//   rdata_i    : memory read word              -> rdata_o : shifted down to bit 0
//   wstrb_o    : byte strobes for the access
//   misalign_o : half not on 2-byte or word not on 4-byte boundary
module mem_lane_align
    import mem_pte_bridge_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  mem_size_e   size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [3:0] base_strb;

    always_comb begin
        base_strb  = 4'hF;
        misalign_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                base_strb  = 4'b0001;
                misalign_o = 1'b0;
            end
            SIZE_H: begin
                base_strb  = 4'b0011;
                misalign_o = offset_i[0];
            end
            default: begin
                // The unused encoding behaves as a word access.
                base_strb  = 4'hF;
                misalign_o = |offset_i;
            end
        endcase
    end

    assign wstrb_o = base_strb << offset_i;
    assign wdata_o = wdata_i << {offset_i, 3'b000};
    assign rdata_o = rdata_i >> {offset_i, 3'b000};

endmodule

// File: rtl/mem_pte_bridge.sv
// Cache-request to word-memory bridge with hardware PTE A/D update.
// Accepts one request at a time (req_ready only when idle), converts
// byte/half/word accesses into strobed word transactions, and for requests
// with nonzero req_pte performs an atomic read / OR-in-A/D / write-back.
// One resp_valid pulse is returned per accepted request.
//   req_*  : upstream request (valid/ready handshake, latched on accept)
//   resp_* : one-cycle response with error flag/type and read data
//   mem_*  : word-addressed memory command (valid/ready) and read return
module mem_pte_bridge
    import mem_pte_bridge_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PTE_A_BIT = 6,
    parameter int PTE_D_BIT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_wmask,
    input  logic [1:0]        req_pte,
    output logic              resp_valid,
    output logic              resp_error,
    output logic [1:0]        resp_errty,
    output logic [31:0]       resp_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rerror
);

    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    mem_size_e         size_q, size_d;
    pte_ad_t           pte_q, pte_d;
    logic [31:0]       pte_word_q, pte_word_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [1:0]        errty_q, errty_d;

    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_misalign;
    logic        is_pte;
    logic        plain_write;
    logic [31:0] pte_new;

    mem_lane_align u_lane (
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .wstrb_o    (lane_wstrb),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata),
        .misalign_o (lane_misalign)
    );

    assign is_pte      = |pte_q;
    // A PTE request always starts with a word read, whatever req_wen said.
    assign plain_write = wen_q & ~is_pte;
    assign pte_new     = mem_rdata | pte_ad_mask(pte_q, PTE_A_BIT, PTE_D_BIT);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        pte_d      = pte_q;
        pte_word_d = pte_word_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        errty_d    = errty_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    size_d  = mem_size_e'(req_wmask);
                    pte_d   = pte_ad_t'(req_pte);
                    err_d   = 1'b0;
                    errty_d = ERR_BUS;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (lane_misalign) begin
                    err_d   = 1'b1;
                    errty_d = ERR_MISALIGN;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_RESP;
                    rdata_d = lane_rdata;
                    if (mem_rerror) begin
                        // A faulted PTE read never gets written back.
                        err_d   = 1'b1;
                        errty_d = ERR_BUS;
                    end else if (is_pte) begin
                        // PTE words are returned whole, never lane-shifted.
                        rdata_d = pte_new;
                        if (pte_new != mem_rdata) begin
                            pte_word_d = pte_new;
                            state_d    = ST_PTE_CMD;
                        end
                    end
                end
            end
            ST_PTE_CMD: begin
                if (mem_ready) begin
                    state_d = ST_PTE_WAIT;
                end
            end
            ST_PTE_WAIT: begin
                if (mem_rvalid) begin
                    if (mem_rerror) begin
                        err_d   = 1'b1;
                        errty_d = ERR_BUS;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            size_q     <= SIZE_B;
            pte_q      <= '0;
            pte_word_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            errty_q    <= ERR_BUS;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            pte_q      <= pte_d;
            pte_word_q <= pte_word_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            errty_q    <= errty_d;
        end
    end

    // Memory command fields are decoded from the state and latched request,
    // so they hold steady for as long as the command is stalled.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_error = err_q;
    assign resp_errty = errty_q;
    assign resp_rdata = rdata_q;
    assign mem_valid  = (state_q == ST_CMD) || (state_q == ST_PTE_CMD);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wen    = ((state_q == ST_CMD) && plain_write) || (state_q == ST_PTE_CMD);
    assign mem_wstrb  = (state_q == ST_PTE_CMD)                  ? 4'hF :
                        ((state_q == ST_CMD) && plain_write)     ? lane_wstrb : 4'h0;
    assign mem_wdata  = (state_q == ST_PTE_CMD) ? pte_word_q : lane_wdata;

endmodule

// File: doc/mem_pte_bridge.md
Name: mem_pte_bridge

Overview:
- Sits directly downstream of the cache-command arbiter: consumes its single outstanding CacheReq stream and drives a word-addressed memory bus.
- Converts byte, half and word accesses into word transactions with byte strobes.
- Performs hardware PTE A/D update as an atomic read-modify-write when the request carries nonzero pte flags.
- Returns one CacheResp per accepted request.

Parameters:
- ADDR_W, 32, request and memory address width.
- PTE_A_BIT, 6, bit position of the Accessed flag in a PTE word.
- PTE_D_BIT, 7, bit position of the Dirty flag in a PTE word.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  bridge can accept a request this cycle.
- req_addr  in  ADDR_W  byte address.
- req_wen  in  1  1 = write.
- req_wdata  in  32  right-aligned write data.
- req_wmask  in  2  MemSize: SIZE_B=0, SIZE_H=1, SIZE_W=2.
- req_pte  in  2  PTE_AD flags {set_d, set_a}; nonzero = A/D update.
- resp_valid  out  1  one-cycle response pulse.
- resp_error  out  1  response carries an error.
- resp_errty  out  2  error type: ERR_BUS=0, ERR_MISALIGN=1.
- resp_rdata  out  32  read data.
- mem_valid  out  1  memory command valid.
- mem_ready  in  1  memory accepts the command.
- mem_addr  out  ADDR_W  word address, low 2 bits zero.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  32  lane-positioned write data.
- mem_wstrb  out  4  byte strobes.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  32  memory read word.
- mem_rerror  in  1  memory bus fault.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_errty=0, resp_rdata=0, mem_valid=0, mem_wen=0, mem_wstrb=0.
- req_ready is 1 only in IDLE. A request is accepted on req_valid & req_ready and latched whole.
- States:
  - IDLE -> CHK on accept.
  - CHK performs the alignment check (H with addr[0]=1, W with addr[1:0]!=0). Misaligned goes to RESP with error=1, errty=ERR_MISALIGN, and no memory access. Otherwise goes to CMD.
  - CMD holds mem_valid=1 with stable fields until mem_ready; then goes to WAIT.
  - WAIT: on mem_rvalid, a plain request goes to RESP. A pte request that is a read without error goes to PTE_CMD if the A/D bits need setting, else to RESP.
  - PTE_CMD issues a full-word write (wstrb=4'hF) of the read word OR'd with the selected A/D bits; on mem_ready goes to PTE_WAIT.
  - PTE_WAIT goes to RESP on mem_rvalid.
  - RESP drives resp_valid=1 for exactly one cycle, then returns to IDLE.
- Write lanes: wdata is shifted left by 8*addr[1:0]. Strobes: B=4'b0001<<addr[1:0], H=4'b0011<<addr[1:0], W=4'hF.
- Reads: resp_rdata = mem_rdata >> 8*addr[1:0]. Upper bits are not masked; extension is done upstream.
- PTE request: the initial access is always a word read regardless of req_wen. resp_rdata is the updated PTE value.
- Errors: mem_rerror on any beat gives resp_error=1, errty=ERR_BUS. A fault on the PTE read suppresses the write-back.
- Memory-side latency: mem_rvalid is accepted no earlier than the cycle after the mem_ready handshake. mem_rvalid in any other state is ignored.
- Minimum latency: accept to resp_valid is 4 cycles with zero-wait memory (IDLE, CHK, CMD, WAIT, then RESP). Add 2 cycles when the PTE write-back occurs.
- mem_valid is never deasserted in CMD or PTE_CMD before mem_ready.
- Reset asserted mid-transaction returns to IDLE immediately and drops mem_valid. An in-flight memory response after reset is ignored.

Decomposition:
- Shared meminf package: MemSize, PTE_AD, ERR_BUS, ERR_MISALIGN, the bridge state enum.
- One natural sub-module, mem_lane_align: combinational wstrb generation, write-data shift, read-data shift, and misalignment detect.

Test Plan:
- SIZE_W read at 0x100, mem_rdata=0xDEADBEEF -> one CMD (addr 0x100, wen=0), resp_rdata=0xDEADBEEF, error=0, resp_valid one cycle.
- SIZE_B write, addr 0x203, wdata=0xAB -> mem_addr=0x200, wstrb=4'b1000, wdata[31:24]=0xAB.
- SIZE_H read at 0x101 -> resp_error=1, errty=ERR_MISALIGN, mem_valid never asserted.
- pte={1,1} at 0x400, read returns 0x00000001 -> write 0x000000C1 with wstrb=4'hF; resp_rdata=0xC1.
- pte={0,1}, read returns 0x41 -> no write-back, resp_rdata=0x41. Same request with mem_rerror=1 on the read -> errty=ERR_BUS, no write.
- mem_ready held low 5 cycles in CMD -> fields stable. Then assert rst_n=0 mid-WAIT -> req_ready=1 and mem_valid=0 next edge; a late mem_rvalid produces no resp_valid.
